jit_emit_buffer: RTL and testbench

- Downstream consumer of the ARM instruction-template ROM in the JVM-to-ARM JIT.
- Accepts template requests from the bytecode translator, drives the ROM index, and patches immediate or branch-offset fields into the returned 32-bit word.
- Assigns each word a code address and buffers words in a FIFO.
- Drains the FIFO to code memory under a valid/ready handshake.

---
 rtl/jit_emit_buffer.sv | 99 +++++++++
 tb/tb_jit_emit_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jit_emit_buffer.sv
// JIT emit buffer: fetches ARM templates from the ROM, patches immediates or branch
// offsets, tags each word with a code address and queues it for code memory.
module jit_emit_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tmpl_valid,
    output logic          tmpl_ready,
    input  logic [6:0]    tmpl_idx,
    input  logic [1:0]    tmpl_mode,
    input  logic [23:0]   tmpl_imm,
    output logic [6:0]    rom_addr,
    input  logic [31:0]   rom_data,
    input  logic          base_load,
    input  logic [AW-1:0] base_addr,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW-1:0] pc_out,
    output logic          idle,
    output logic          err_bad_idx
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] pc;
    logic          err_q;

    logic        empty, full, accept, skip, bad, push, pop;
    logic [23:0] off;
    logic [31:0] patched;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign tmpl_ready = !full && !base_load;
    assign accept     = tmpl_valid && tmpl_ready;
    assign skip       = (tmpl_idx == 7'd0);
    assign bad        = (rom_data == 32'hFFFF_FFFF);
    assign push       = accept && !skip && !bad;
    assign pop        = !empty && mem_ready;
    assign rom_addr   = tmpl_idx;

    // Branch offset in words relative to the ARM PC (current + 2 words).
    assign off = tmpl_imm - (24'(pc) + 24'd2);

    always_comb begin
        patched = rom_data;
        unique case (tmpl_mode)
            2'b01:   patched = {rom_data[31:8], tmpl_imm[7:0]};
            2'b10:   patched = {rom_data[31:24], off};
            2'b11:   patched = {rom_data[31:12], tmpl_imm[11:0]};
            default: patched = rom_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pc     <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // base_load only retargets an empty buffer; it also blocks accepts, so no push races it.
            if (base_load && empty) pc <= base_addr;
            else if (push)          pc <= pc + AW'(1);
            if (accept && !skip && bad) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= pc;
            data_mem[wr_ptr] <= patched;
        end
    end

    assign mem_we      = !empty;
    assign mem_addr    = empty ? '0 : addr_mem[rd_ptr];
    assign mem_wdata   = empty ? '0 : data_mem[rd_ptr];
    assign pc_out      = pc;
    assign idle        = empty;
    assign err_bad_idx = err_q;
endmodule

// File: tb/tb_jit_emit_buffer.sv
// Directed bench for jit_emit_buffer: expected words queued at accept, checked as they drain.
module tb_jit_emit_buffer;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          tmpl_valid, tmpl_ready;
    logic [6:0]    tmpl_idx;
    logic [1:0]    tmpl_mode;
    logic [23:0]   tmpl_imm;
    logic [6:0]    rom_addr;
    logic [31:0]   rom_data;
    logic          base_load;
    logic [AW-1:0] base_addr;
    logic          mem_we, mem_ready;
    logic [AW-1:0] mem_addr, pc_out;
    logic [31:0]   mem_wdata;
    logic          idle, err_bad_idx;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] exp_addr [$];
    logic [31:0]   exp_data [$];

    jit_emit_buffer #(.DEPTH(8), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .tmpl_valid(tmpl_valid), .tmpl_ready(tmpl_ready),
        .tmpl_idx(tmpl_idx), .tmpl_mode(tmpl_mode), .tmpl_imm(tmpl_imm),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .base_load(base_load), .base_addr(base_addr),
        .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc_out(pc_out), .idle(idle), .err_bad_idx(err_bad_idx)
    );

    always #5 clk = ~clk;

    // Template ROM model
    always_comb begin
        case (rom_addr)
            7'h01:   rom_data = 32'hE49D0004;
            7'h22:   rom_data = 32'hC3A00001;
            7'h2C:   rom_data = 32'hEBFFFFFE;
            7'h30:   rom_data = 32'hE3A01000;
            7'h50:   rom_data = 32'hFFFFFFFF;
            default: rom_data = 32'hE1A00000;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: each pop handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (exp_addr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got addr %h data %h, expected none", mem_addr, mem_wdata);
            end else begin
                chk("pop_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                chk("pop_data", mem_wdata, exp_data.pop_front());
            end
        end
    end

    // Offer one request (called just after a posedge); waits bounded for acceptance.
    task automatic offer(input logic [6:0] idx, input logic [1:0] mode, input logic [23:0] imm,
                         input bit do_push, input logic [AW-1:0] e_addr, input logic [31:0] e_data);
        tmpl_valid = 1'b1;
        tmpl_idx   = idx;
        tmpl_mode  = mode;
        tmpl_imm   = imm;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tmpl_ready) begin
                if (do_push) begin
                    exp_addr.push_back(e_addr);
                    exp_data.push_back(e_data);
                end
                @(posedge clk); #1;
                tmpl_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(tmpl_ready), 32'd1);
        tmpl_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (idle) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("idle_timeout", 32'(idle), 32'd1);
    endtask

    task automatic load_base(input logic [AW-1:0] a);
        base_load = 1'b1;
        base_addr = a;
        #1 chk("ready_low_on_base_load", 32'(tmpl_ready), 32'd0);
        @(posedge clk); #1;
        base_load = 1'b0;
        chk("pc_after_base_load", 32'(pc_out), 32'(a));
    endtask

    initial begin
        rst = 1'b1; tmpl_valid = 1'b0; tmpl_idx = '0; tmpl_mode = '0; tmpl_imm = '0;
        base_load = 1'b0; base_addr = '0; mem_ready = 1'b0;
        #3;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(tmpl_ready), 32'd1);
        chk("rst_err", 32'(err_bad_idx), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // First word, head visible the cycle after accept
        load_base(16'h0100);
        offer(7'h01, 2'b00, 24'h0, 1'b1, 16'h0100, 32'hE49D0004);
        chk("head_we", 32'(mem_we), 32'd1);
        chk("head_addr", 32'(mem_addr), 32'h0100);
        chk("head_data", mem_wdata, 32'hE49D0004);
        chk("pc_0101", 32'(pc_out), 32'h0101);
        chk("not_idle", 32'(idle), 32'd0);
        mem_ready = 1'b1;
        wait_idle();

        // Patch modes, skip index and unmapped index
        load_base(16'h0200);
        offer(7'h2C, 2'b10, 24'h000150, 1'b1, 16'h0200, 32'hEBFFFF4E);
        offer(7'h22, 2'b01, 24'h00007F, 1'b1, 16'h0201, 32'hC3A0007F);
        chk("pc_0202", 32'(pc_out), 32'h0202);
        offer(7'h00, 2'b00, 24'h0, 1'b0, '0, '0);
        chk("pc_skip", 32'(pc_out), 32'h0202);
        offer(7'h30, 2'b11, 24'h123ABC, 1'b1, 16'h0202, 32'hE3A01ABC);
        offer(7'h50, 2'b01, 24'h000011, 1'b0, '0, '0);
        chk("err_set", 32'(err_bad_idx), 32'd1);
        chk("pc_bad_idx", 32'(pc_out), 32'h0203);
        offer(7'h01, 2'b00, 24'h0, 1'b1, 16'h0203, 32'hE49D0004);
        chk("err_sticky", 32'(err_bad_idx), 32'd1);
        wait_idle();

        // Fill to full with memory stalled
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            offer(7'h01, 2'b01, 24'(i), 1'b1, 16'h0204 + 16'(i), 32'hE49D0000 | 32'(i));
        chk("full_ready_low", 32'(tmpl_ready), 32'd0);
        tmpl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_addr", 32'(mem_addr), 32'h0204);
            chk("stall_data", mem_wdata, 32'hE49D0000);
        end
        // Release memory with requests held: first cycle pops only, then push+pop
        mem_ready = 1'b1;
        offer(7'h01, 2'b01, 24'h08, 1'b1, 16'h020C, 32'hE49D0008);
        offer(7'h01, 2'b01, 24'h09, 1'b1, 16'h020D, 32'hE49D0009);
        wait_idle();

        // base_load ignored while non-empty
        mem_ready = 1'b0;
        offer(7'h01, 2'b00, 24'h0, 1'b1, 16'h020E, 32'hE49D0004);
        chk("pc_020f", 32'(pc_out), 32'h020F);
        base_load = 1'b1;
        base_addr = 16'h0500;
        tmpl_valid = 1'b1;
        #1 chk("busy_base_ready", 32'(tmpl_ready), 32'd0);
        @(posedge clk); #1;
        chk("busy_base_pc", 32'(pc_out), 32'h020F);
        chk("busy_base_head", 32'(mem_addr), 32'h020E);
        base_load = 1'b0;
        tmpl_valid = 1'b0;

        // Asynchronous reset mid-drain discards contents
        #2 rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_pc", 32'(pc_out), 32'd0);
        chk("arst_err", 32'(err_bad_idx), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("leftover_expected", 32'(exp_addr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
